// File: rtl/teeter_pkg.sv
// Shared constants and state encoding for the teeter hole-scan logic.
// Coordinates are unsigned pixel positions; differences carry one extra sign bit.
package teeter_pkg;

    localparam int COORD_W    = 10;
    localparam int DEF_RADIUS = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_FLUSH = 2'd2
    } scan_state_t;

endpackage

// File: rtl/dist_sq_cmp.sv
// Squared-distance compare: hit when dx*dx + dy*dy <= RADIUS*RADIUS.
// Purely combinational; the controller time-shares one instance across all entries.
module dist_sq_cmp
    import teeter_pkg::*;
#(
    parameter int RADIUS = DEF_RADIUS
) (
    input  logic signed [COORD_W:0] i_dx,
    input  logic signed [COORD_W:0] i_dy,
    output logic                    o_hit
);

    localparam int SQ_W = 2 * COORD_W + 2;
    localparam logic [SQ_W-1:0] R_SQ = SQ_W'(RADIUS * RADIUS);

    logic [COORD_W-1:0] mag_x;
    logic [COORD_W-1:0] mag_y;
    logic [SQ_W-1:0]    sq_x;
    logic [SQ_W-1:0]    sq_y;
    logic [SQ_W-1:0]    sum_sq;

    // Differences of two unsigned 10-bit values never reach -1024, so the
    // magnitude always fits in COORD_W bits.
    always_comb begin
        mag_x  = COORD_W'(i_dx[COORD_W] ? -i_dx : i_dx);
        mag_y  = COORD_W'(i_dy[COORD_W] ? -i_dy : i_dy);
        sq_x   = SQ_W'(mag_x) * SQ_W'(mag_x);
        sq_y   = SQ_W'(mag_y) * SQ_W'(mag_y);
        sum_sq = sq_x + sq_y;
        o_hit  = (sum_sq <= R_SQ);
    end

endmodule

// File: rtl/hole_scan_ctrl.sv
// Hole-table scan controller: checks the latched ball position against every
// active hole and reports the lowest-index hit, one entry per cycle.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for i_start; hole table writable
//   ST_SCAN  | issuing entry idx 0..NUM_HOLES-1 into the dx/dy stage
//   ST_FLUSH | draining compare pipeline; publishes result and o_done
module hole_scan_ctrl
    import teeter_pkg::*;
#(
    parameter  int NUM_HOLES = 8,
    parameter  int RADIUS    = DEF_RADIUS,
    localparam int IDX_W     = $clog2(NUM_HOLES)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cfg_we,
    input  logic [IDX_W-1:0]   i_cfg_idx,
    input  logic [COORD_W-1:0] i_cfg_x,
    input  logic [COORD_W-1:0] i_cfg_y,
    input  logic               i_cfg_en,
    input  logic               i_start,
    input  logic [COORD_W-1:0] i_bl_x,
    input  logic [COORD_W-1:0] i_bl_y,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_fall_in,
    output logic [IDX_W-1:0]   o_hole_idx
);

    scan_state_t state_q, state_d;

    logic [COORD_W-1:0] tbl_x_q [NUM_HOLES];
    logic [COORD_W-1:0] tbl_x_d [NUM_HOLES];
    logic [COORD_W-1:0] tbl_y_q [NUM_HOLES];
    logic [COORD_W-1:0] tbl_y_d [NUM_HOLES];
    logic [NUM_HOLES-1:0] tbl_en_q, tbl_en_d;

    // Snapshot taken at start so a same-edge config write cannot leak into the scan.
    logic [COORD_W-1:0] shd_x_q [NUM_HOLES];
    logic [COORD_W-1:0] shd_x_d [NUM_HOLES];
    logic [COORD_W-1:0] shd_y_q [NUM_HOLES];
    logic [COORD_W-1:0] shd_y_d [NUM_HOLES];
    logic [NUM_HOLES-1:0] shd_en_q, shd_en_d;

    logic [COORD_W-1:0] ball_x_q, ball_x_d;
    logic [COORD_W-1:0] ball_y_q, ball_y_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic                    s1_vld_q, s1_vld_d;
    logic                    s1_last_q, s1_last_d;
    logic [IDX_W-1:0]        s1_idx_q, s1_idx_d;
    logic                    s1_en_q, s1_en_d;
    logic signed [COORD_W:0] s1_dx_q, s1_dx_d;
    logic signed [COORD_W:0] s1_dy_q, s1_dy_d;

    logic             s2_vld_q, s2_vld_d;
    logic             s2_last_q, s2_last_d;
    logic [IDX_W-1:0] s2_idx_q, s2_idx_d;
    logic             s2_hit_q, s2_hit_d;

    logic             found_q, found_d;
    logic [IDX_W-1:0] found_idx_q, found_idx_d;

    logic             done_q, done_d;
    logic             fall_q, fall_d;
    logic [IDX_W-1:0] hole_idx_q, hole_idx_d;

    logic cmp_hit;

    dist_sq_cmp #(
        .RADIUS (RADIUS)
    ) u_dist_sq_cmp (
        .i_dx  (s1_dx_q),
        .i_dy  (s1_dy_q),
        .o_hit (cmp_hit)
    );

    always_comb begin
        state_d     = state_q;
        tbl_x_d     = tbl_x_q;
        tbl_y_d     = tbl_y_q;
        tbl_en_d    = tbl_en_q;
        shd_x_d     = shd_x_q;
        shd_y_d     = shd_y_q;
        shd_en_d    = shd_en_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        idx_d       = idx_q;
        s1_vld_d    = 1'b0;
        s1_last_d   = 1'b0;
        s1_idx_d    = s1_idx_q;
        s1_en_d     = s1_en_q;
        s1_dx_d     = s1_dx_q;
        s1_dy_d     = s1_dy_q;
        s2_vld_d    = s1_vld_q;
        s2_last_d   = s1_vld_q & s1_last_q;
        s2_idx_d    = s1_idx_q;
        s2_hit_d    = s1_vld_q & s1_en_q & cmp_hit;
        found_d     = found_q;
        found_idx_d = found_idx_q;
        done_d      = 1'b0;
        fall_d      = fall_q;
        hole_idx_d  = hole_idx_q;

        if (s2_vld_q && s2_hit_q && !found_q) begin
            found_d     = 1'b1;
            found_idx_d = s2_idx_q;
        end

        if (i_cfg_we && state_q == ST_IDLE) begin
            tbl_x_d[i_cfg_idx]  = i_cfg_x;
            tbl_y_d[i_cfg_idx]  = i_cfg_y;
            tbl_en_d[i_cfg_idx] = i_cfg_en;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d     = ST_SCAN;
                    ball_x_d    = i_bl_x;
                    ball_y_d    = i_bl_y;
                    idx_d       = '0;
                    shd_x_d     = tbl_x_q;
                    shd_y_d     = tbl_y_q;
                    shd_en_d    = tbl_en_q;
                    found_d     = 1'b0;
                    found_idx_d = '0;
                end
            end
            ST_SCAN: begin
                s1_vld_d  = 1'b1;
                s1_idx_d  = idx_q;
                s1_en_d   = shd_en_q[idx_q];
                s1_dx_d   = $signed({1'b0, ball_x_q}) - $signed({1'b0, shd_x_q[idx_q]});
                s1_dy_d   = $signed({1'b0, ball_y_q}) - $signed({1'b0, shd_y_q[idx_q]});
                s1_last_d = (idx_q == IDX_W'(NUM_HOLES - 1));
                if (s1_last_d) begin
                    state_d = ST_FLUSH;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_FLUSH: begin
                // Last entry's hit is still in stage 2, so merge it here.
                if (s2_last_q) begin
                    state_d    = ST_IDLE;
                    done_d     = 1'b1;
                    fall_d     = found_q | s2_hit_q;
                    hole_idx_d = found_q  ? found_idx_q :
                                 s2_hit_q ? s2_idx_q    : '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            tbl_en_q    <= '0;
            shd_en_q    <= '0;
            ball_x_q    <= '0;
            ball_y_q    <= '0;
            idx_q       <= '0;
            s1_vld_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_idx_q    <= '0;
            s1_en_q     <= 1'b0;
            s1_dx_q     <= '0;
            s1_dy_q     <= '0;
            s2_vld_q    <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_idx_q    <= '0;
            s2_hit_q    <= 1'b0;
            found_q     <= 1'b0;
            found_idx_q <= '0;
            done_q      <= 1'b0;
            fall_q      <= 1'b0;
            hole_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            tbl_en_q    <= tbl_en_d;
            shd_en_q    <= shd_en_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            idx_q       <= idx_d;
            s1_vld_q    <= s1_vld_d;
            s1_last_q   <= s1_last_d;
            s1_idx_q    <= s1_idx_d;
            s1_en_q     <= s1_en_d;
            s1_dx_q     <= s1_dx_d;
            s1_dy_q     <= s1_dy_d;
            s2_vld_q    <= s2_vld_d;
            s2_last_q   <= s2_last_d;
            s2_idx_q    <= s2_idx_d;
            s2_hit_q    <= s2_hit_d;
            found_q     <= found_d;
            found_idx_q <= found_idx_d;
            done_q      <= done_d;
            fall_q      <= fall_d;
            hole_idx_q  <= hole_idx_d;
        end
    end

    // Coordinate storage carries no reset; only the enable bits matter after reset.
    always_ff @(posedge i_clk) begin
        tbl_x_q <= tbl_x_d;
        tbl_y_q <= tbl_y_d;
        shd_x_q <= shd_x_d;
        shd_y_q <= shd_y_d;
    end

    assign o_busy     = (state_q != ST_IDLE);
    assign o_done     = done_q;
    assign o_fall_in  = fall_q;
    assign o_hole_idx = hole_idx_q;

endmodule

// File: tb/tb_hole_scan_ctrl.sv
// Directed bench for hole_scan_ctrl: hand-computed scan results, latency,
// boundary distance, busy-time write/start rejection and mid-scan reset.
module tb_hole_scan_ctrl;

    localparam int N     = 8;
    localparam int IDX_W = 3;
    localparam int LAT   = N + 2;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_cfg_we;
    logic [IDX_W-1:0] i_cfg_idx;
    logic [9:0]       i_cfg_x;
    logic [9:0]       i_cfg_y;
    logic             i_cfg_en;
    logic             i_start;
    logic [9:0]       i_bl_x;
    logic [9:0]       i_bl_y;
    logic             o_busy;
    logic             o_done;
    logic             o_fall_in;
    logic [IDX_W-1:0] o_hole_idx;

    int n_vec = 0;
    int n_err = 0;

    hole_scan_ctrl #(.NUM_HOLES(N), .RADIUS(16)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_cfg_we   (i_cfg_we),
        .i_cfg_idx  (i_cfg_idx),
        .i_cfg_x    (i_cfg_x),
        .i_cfg_y    (i_cfg_y),
        .i_cfg_en   (i_cfg_en),
        .i_start    (i_start),
        .i_bl_x     (i_bl_x),
        .i_bl_y     (i_bl_y),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_fall_in  (o_fall_in),
        .o_hole_idx (o_hole_idx)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_vec(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic cfg_write(input int idx, input int x, input int y, input bit en);
        i_cfg_we  = 1'b1;
        i_cfg_idx = IDX_W'(idx);
        i_cfg_x   = 10'(x);
        i_cfg_y   = 10'(y);
        i_cfg_en  = en;
        tick();
        i_cfg_we  = 1'b0;
    endtask

    task automatic run_scan(input string tag, input int bx, input int by,
                            input bit exp_fall, input int exp_idx);
        int n;
        i_start = 1'b1;
        i_bl_x  = 10'(bx);
        i_bl_y  = 10'(by);
        tick();
        i_start = 1'b0;
        check_vec({tag, "_busy"}, int'(o_busy), 1);
        n = 0;
        while (!o_done && n < 40) begin
            tick();
            n++;
        end
        check_vec({tag, "_lat"}, n, LAT);
        check_vec({tag, "_fall"}, int'(o_fall_in), int'(exp_fall));
        check_vec({tag, "_idx"}, int'(o_hole_idx), exp_idx);
        check_vec({tag, "_busy_end"}, int'(o_busy), 0);
        tick();
        check_vec({tag, "_done_pulse"}, int'(o_done), 0);
        check_vec({tag, "_hold"}, int'(o_fall_in), int'(exp_fall));
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    initial begin
        int done_cnt;
        int got_idx;
        i_rst = 1'b1; i_cfg_we = 1'b0; i_cfg_idx = '0; i_cfg_x = '0; i_cfg_y = '0;
        i_cfg_en = 1'b0; i_start = 1'b0; i_bl_x = '0; i_bl_y = '0;
        do_reset();
        check_vec("rst_busy", int'(o_busy), 0);
        check_vec("rst_done", int'(o_done), 0);
        check_vec("rst_fall", int'(o_fall_in), 0);
        check_vec("rst_idx", int'(o_hole_idx), 0);

        // Single hole, dist^2 = 200
        cfg_write(3, 100, 100, 1'b1);
        run_scan("h3", 110, 110, 1'b1, 3);

        // Two holes at exact radius; lowest wins. One pixel further misses.
        cfg_write(2, 50, 50, 1'b1);
        cfg_write(5, 50, 50, 1'b1);
        run_scan("bnd16", 50, 66, 1'b1, 2);
        run_scan("bnd17", 50, 67, 1'b0, 0);

        // Disabled entry, far-away ball with no wrap, negative dx hit
        do_reset();
        cfg_write(0, 50, 50, 1'b0);
        run_scan("dis", 50, 50, 1'b0, 0);
        cfg_write(1, 5, 5, 1'b1);
        run_scan("nowrap", 1000, 5, 1'b0, 0);
        cfg_write(7, 1010, 5, 1'b1);
        run_scan("negdx", 1000, 5, 1'b1, 7);

        // Start and write on the same IDLE edge: scan uses old entry 6
        i_cfg_we = 1'b1; i_cfg_idx = 3'd6; i_cfg_x = 10'd1010; i_cfg_y = 10'd5; i_cfg_en = 1'b1;
        run_scan("same_edge", 1010, 5, 1'b1, 7);
        i_cfg_we = 1'b0;
        run_scan("same_edge_after", 1010, 5, 1'b1, 6);

        // Busy-time start and write are dropped
        do_reset();
        cfg_write(7, 1010, 5, 1'b1);
        i_start = 1'b1; i_bl_x = 10'd1010; i_bl_y = 10'd5;
        tick();
        i_start = 1'b0;
        tick();
        tick();
        i_start = 1'b1;
        i_cfg_we = 1'b1; i_cfg_idx = 3'd6; i_cfg_x = 10'd1010; i_cfg_y = 10'd5; i_cfg_en = 1'b1;
        tick();
        i_start = 1'b0;
        i_cfg_we = 1'b0;
        done_cnt = 0;
        got_idx = -1;
        for (int c = 0; c < 30; c++) begin
            if (o_done) begin
                done_cnt++;
                got_idx = int'(o_hole_idx);
            end
            tick();
        end
        check_vec("busy_done_cnt", done_cnt, 1);
        check_vec("busy_idx", got_idx, 7);
        run_scan("busy_after", 1010, 5, 1'b1, 7);

        // Reset sampled at edge 4 of a hitting scan
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        tick();
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check_vec("mid_rst_busy", int'(o_busy), 0);
        check_vec("mid_rst_fall", int'(o_fall_in), 0);
        check_vec("mid_rst_idx", int'(o_hole_idx), 0);
        done_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (o_done) done_cnt++;
            tick();
        end
        check_vec("mid_rst_no_done", done_cnt, 0);
        run_scan("post_rst", 1010, 5, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
